// File: rtl/ama_riscv_reg_file_mp_pkg.sv
// Shared register-file types, constants and helpers for the multi-port RF
// and its pending-write scoreboard.
package ama_riscv_reg_file_mp_pkg;

  localparam int RF_NUM       = 32;
  localparam int ARCH_WIDTH   = 32;
  localparam int MAX_RD_PORTS = 4;

  typedef logic [$clog2(RF_NUM)-1:0] rf_addr_t;
  typedef logic [ARCH_WIDTH-1:0]     arch_width_t;

  localparam rf_addr_t RF_X0_ZERO = 5'd0;
  localparam rf_addr_t RF_X31_T6  = 5'd31;

  // Qualified write request as seen by storage, bypass and scoreboard
  typedef struct packed {
    logic     rd_en;
    logic     rdp_en;
    rf_addr_t rd;
    rf_addr_t rdp;
  } rf_wq_t;

  // Paired destination is the next register up; x31 wraps to x0 (no pair)
  function automatic rf_addr_t get_rdp(input rf_addr_t rd);
    return rd + rf_addr_t'(1);
  endfunction

  function automatic logic sb_busy(input logic [RF_NUM-1:0] sb, input rf_addr_t a);
    return sb[a] && (a != RF_X0_ZERO);
  endfunction

endpackage

// File: rtl/ama_riscv_reg_file_mp_if.sv
// Read/write/scoreboard bundle between decode, writeback and the register file.
interface ama_riscv_reg_file_mp_if #(
  parameter int NUM_RD_PORTS = 2
) ();
  import ama_riscv_reg_file_mp_pkg::*;

  rf_addr_t    [NUM_RD_PORTS-1:0] addr_r;
  arch_width_t [NUM_RD_PORTS-1:0] data_r;
  logic        [NUM_RD_PORTS-1:0] busy_r;
  logic                           we;
  logic                           we_p;
  rf_addr_t                       addr_d;
  arch_width_t                    data_d;
  arch_width_t                    data_dp;
  logic                           sb_set;
  rf_addr_t                       addr_sb;
  logic                           any_busy;

  modport master (
    output addr_r, we, we_p, addr_d, data_d, data_dp, sb_set, addr_sb,
    input  data_r, busy_r, any_busy
  );

  modport slave (
    input  addr_r, we, we_p, addr_d, data_d, data_dp, sb_set, addr_sb,
    output data_r, busy_r, any_busy
  );

endinterface

// File: rtl/ama_riscv_reg_file_mp_scoreboard.sv
// Per-register pending-write bits: set by long-latency issue, cleared by writeback.
module ama_riscv_reg_file_mp_scoreboard
  import ama_riscv_reg_file_mp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  rf_addr_t          addr_set,
  input  logic              clr_a,
  input  rf_addr_t          addr_clr_a,
  input  logic              clr_b,
  input  rf_addr_t          addr_clr_b,
  output logic [RF_NUM-1:0] sb,
  output logic              any_busy
);

  logic [RF_NUM-1:0] sb_nxt;

  // Set applied last: a new producer supersedes the one returning this cycle
  always_comb begin
    sb_nxt = sb;
    if (clr_a) sb_nxt[addr_clr_a] = 1'b0;
    if (clr_b) sb_nxt[addr_clr_b] = 1'b0;
    if (set)   sb_nxt[addr_set]   = 1'b1;
    sb_nxt[RF_X0_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sb_nxt;
  end

  assign any_busy = |sb;

endmodule

// File: rtl/ama_riscv_reg_file_mp.sv
// Multi-port integer register file with paired write, write-to-read bypass
// and pending-write scoreboard.
module ama_riscv_reg_file_mp
  import ama_riscv_reg_file_mp_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int BYPASS       = 1,
  parameter int RESET_REGS   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  ama_riscv_reg_file_mp_if.slave    rf_if
);

  if (NUM_RD_PORTS < 1 || NUM_RD_PORTS > MAX_RD_PORTS) begin : g_bad_ports
    $error("NUM_RD_PORTS out of range");
  end

  arch_width_t       rf [RF_NUM];
  logic [RF_NUM-1:0] sb;
  rf_wq_t            wq;

  // x31 has no pair: get_rdp wraps to x0, which also disqualifies the rdp write
  always_comb begin
    wq.rd     = rf_if.addr_d;
    wq.rdp    = get_rdp(rf_if.addr_d);
    wq.rd_en  = rf_if.we && (rf_if.addr_d != RF_X0_ZERO);
    wq.rdp_en = rf_if.we && rf_if.we_p && (wq.rdp != RF_X0_ZERO) &&
                (rf_if.addr_d != RF_X31_T6);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_REGS != 0)
        for (int k = 0; k < RF_NUM; k++) rf[k] <= '0;
    end else begin
      if (wq.rd_en)  rf[wq.rd]  <= rf_if.data_d;
      if (wq.rdp_en) rf[wq.rdp] <= rf_if.data_dp;
    end
  end

  ama_riscv_reg_file_mp_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set        (rf_if.sb_set),
    .addr_set   (rf_if.addr_sb),
    .clr_a      (wq.rd_en),
    .addr_clr_a (wq.rd),
    .clr_b      (wq.rdp_en),
    .addr_clr_b (wq.rdp),
    .sb         (sb),
    .any_busy   (rf_if.any_busy)
  );

  genvar g;
  for (g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
    rf_addr_t    a;
    arch_width_t d;
    logic        b;

    assign a = rf_if.addr_r[g];

    // rd checked last so it wins over rdp
    always_comb begin
      d = rf[a];
      b = sb_busy(sb, a);
      if (BYPASS != 0) begin
        if (wq.rdp_en && (a == wq.rdp)) begin
          d = rf_if.data_dp;
          b = 1'b0;
        end
        if (wq.rd_en && (a == wq.rd)) begin
          d = rf_if.data_d;
          b = 1'b0;
        end
      end
      if (a == RF_X0_ZERO) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rf_if.data_r[g] = d;
    assign rf_if.busy_r[g] = b;
  end

  x31_pair_chk: assert property (@(posedge clk) disable iff (rst)
    !(rf_if.we && rf_if.we_p && (rf_if.addr_d == RF_X31_T6)))
    else $fatal(1, "paired write with rd=x31");

endmodule

// File: tb/tb_ama_riscv_reg_file_mp.sv
// Directed table plus randomized run for two RF configurations sharing inputs:
// A = bypass on, reset clears regs; B = bypass off, regs retained over reset.
module tb_ama_riscv_reg_file_mp;
  import ama_riscv_reg_file_mp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ama_riscv_reg_file_mp_if #(.NUM_RD_PORTS(2)) ifa ();
  ama_riscv_reg_file_mp_if #(.NUM_RD_PORTS(2)) ifb ();

  assign ifb.addr_r  = ifa.addr_r;
  assign ifb.we      = ifa.we;
  assign ifb.we_p    = ifa.we_p;
  assign ifb.addr_d  = ifa.addr_d;
  assign ifb.data_d  = ifa.data_d;
  assign ifb.data_dp = ifa.data_dp;
  assign ifb.sb_set  = ifa.sb_set;
  assign ifb.addr_sb = ifa.addr_sb;

  ama_riscv_reg_file_mp #(.NUM_RD_PORTS(2), .BYPASS(1), .RESET_REGS(1)) dut_a (
    .clk(clk), .rst(rst), .rf_if(ifa));
  ama_riscv_reg_file_mp #(.NUM_RD_PORTS(2), .BYPASS(0), .RESET_REGS(0)) dut_b (
    .clk(clk), .rst(rst), .rf_if(ifb));

  int errors = 0;
  int checks = 0;

  // reference state: architectural contents per config and pending set
  bit [31:0] mrf_a [32];
  bit [31:0] mrf_b [32];
  bit        mpend [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic wp, input rf_addr_t ad,
                       input arch_width_t dd, input arch_width_t ddp, input logic s,
                       input rf_addr_t as, input rf_addr_t r0, input rf_addr_t r1);
    @(negedge clk);
    rst          = r;
    ifa.we       = w;
    ifa.we_p     = wp;
    ifa.addr_d   = ad;
    ifa.data_d   = dd;
    ifa.data_dp  = ddp;
    ifa.sb_set   = s;
    ifa.addr_sb  = as;
    ifa.addr_r[0] = r0;
    ifa.addr_r[1] = r1;
    #1;
  endtask

  function automatic bit pair_valid();
    return ifa.we && ifa.we_p && ifa.addr_d != 5'd31;
  endfunction

  // expected read result for register a in the current cycle
  function automatic logic [31:0] m_data(input rf_addr_t a, input bit byp, input bit useb);
    int pa;
    pa = int'(ifa.addr_d) + 1;
    if (a == 0) return 32'h0;
    if (byp && ifa.we && a == ifa.addr_d) return ifa.data_d;
    if (byp && pair_valid() && int'(a) == pa) return ifa.data_dp;
    return useb ? mrf_b[a] : mrf_a[a];
  endfunction

  function automatic logic m_busy(input rf_addr_t a, input bit byp);
    int pa;
    pa = int'(ifa.addr_d) + 1;
    if (a == 0) return 1'b0;
    if (byp && ifa.we && a == ifa.addr_d) return 1'b0;
    if (byp && pair_valid() && int'(a) == pa) return 1'b0;
    return mpend[a];
  endfunction

  task automatic tick();
    int pa;
    @(posedge clk);
    pa = int'(ifa.addr_d) + 1;
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        mpend[k] = 1'b0;
        mrf_a[k] = 32'h0;
      end
    end else begin
      if (ifa.we && ifa.addr_d != 0) begin
        mrf_a[ifa.addr_d] = ifa.data_d;
        mrf_b[ifa.addr_d] = ifa.data_d;
        mpend[ifa.addr_d] = 1'b0;
      end
      if (pair_valid()) begin
        mrf_a[pa] = ifa.data_dp;
        mrf_b[pa] = ifa.data_dp;
        mpend[pa] = 1'b0;
      end
      if (ifa.sb_set && ifa.addr_sb != 0) mpend[ifa.addr_sb] = 1'b1;
    end
  endtask

  typedef struct {
    logic        rst, we, we_p;
    rf_addr_t    ad;
    arch_width_t dd, ddp;
    logic        sbs;
    rf_addr_t    asb, r0, r1;
    arch_width_t a0, a1, b0, b1;
    logic        abz0, bbz0, any;
  } vec_t;

  function automatic vec_t v(input logic r, w, wp, input rf_addr_t ad, input arch_width_t dd, ddp,
                             input logic s, input rf_addr_t as, r0, r1,
                             input arch_width_t a0, a1, b0, b1, input logic az, bz, an);
    vec_t t;
    t.rst = r; t.we = w; t.we_p = wp; t.ad = ad; t.dd = dd; t.ddp = ddp;
    t.sbs = s; t.asb = as; t.r0 = r0; t.r1 = r1;
    t.a0 = a0; t.a1 = a1; t.b0 = b0; t.b1 = b1; t.abz0 = az; t.bbz0 = bz; t.any = an;
    return t;
  endfunction

  vec_t tbl [23];

  initial begin
    //             rst we wp ad  dd       ddp   sb as r0  r1   a0      a1      b0      b1     az bz any
    tbl[0]  = v(0, 0, 0, 0,  0,       0,    0, 0, 5,  5,  0,      0,      0,      0,      0, 0, 0);
    tbl[1]  = v(0, 1, 0, 0,  'hDEAD,  0,    0, 0, 0,  0,  0,      0,      0,      0,      0, 0, 0);
    tbl[2]  = v(0, 0, 0, 0,  0,       0,    0, 0, 0,  0,  0,      0,      0,      0,      0, 0, 0);
    tbl[3]  = v(0, 1, 0, 7,  'h1234,  0,    0, 0, 7,  7,  'h1234, 'h1234, 0,      0,      0, 0, 0);
    tbl[4]  = v(0, 0, 0, 0,  0,       0,    0, 0, 7,  7,  'h1234, 'h1234, 'h1234, 'h1234, 0, 0, 0);
    tbl[5]  = v(0, 1, 1, 10, 'hA,     'hB,  0, 0, 11, 10, 'hB,    'hA,    0,      0,      0, 0, 0);
    tbl[6]  = v(0, 0, 0, 0,  0,       0,    0, 0, 10, 11, 'hA,    'hB,    'hA,    'hB,    0, 0, 0);
    tbl[7]  = v(0, 0, 1, 10, 'h77,    'h88, 0, 0, 10, 11, 'hA,    'hB,    'hA,    'hB,    0, 0, 0);
    tbl[8]  = v(0, 0, 0, 0,  0,       0,    0, 0, 10, 11, 'hA,    'hB,    'hA,    'hB,    0, 0, 0);
    tbl[9]  = v(0, 0, 0, 0,  0,       0,    1, 12, 12, 12, 0,     0,      0,      0,      0, 0, 0);
    tbl[10] = v(0, 0, 0, 0,  0,       0,    0, 0, 12, 12, 0,      0,      0,      0,      1, 1, 1);
    tbl[11] = v(0, 1, 0, 12, 'h55,    0,    0, 0, 12, 12, 'h55,   'h55,   0,      0,      0, 1, 1);
    tbl[12] = v(0, 0, 0, 0,  0,       0,    0, 0, 12, 12, 'h55,   'h55,   'h55,   'h55,   0, 0, 0);
    tbl[13] = v(0, 1, 0, 12, 'h66,    0,    1, 12, 12, 12, 'h66,  'h66,   'h55,   'h55,   0, 0, 0);
    tbl[14] = v(0, 0, 0, 0,  0,       0,    0, 0, 12, 12, 'h66,   'h66,   'h66,   'h66,   1, 1, 1);
    tbl[15] = v(0, 0, 0, 0,  0,       0,    1, 3, 3,  12, 0,      'h66,   0,      'h66,   0, 0, 1);
    tbl[16] = v(0, 0, 0, 0,  0,       0,    0, 0, 3,  12, 0,      'h66,   0,      'h66,   1, 1, 1);
    tbl[17] = v(1, 0, 0, 0,  0,       0,    0, 0, 3,  12, 0,      'h66,   0,      'h66,   1, 1, 1);
    tbl[18] = v(0, 0, 0, 0,  0,       0,    0, 0, 3,  12, 0,      0,      0,      'h66,   0, 0, 0);
    tbl[19] = v(0, 1, 0, 3,  'h9,     0,    0, 0, 3,  12, 'h9,    0,      0,      'h66,   0, 0, 0);
    tbl[20] = v(0, 0, 0, 0,  0,       0,    0, 0, 3,  12, 'h9,    0,      'h9,    'h66,   0, 0, 0);
    tbl[21] = v(0, 0, 0, 0,  0,       0,    1, 0, 0,  0,  0,      0,      0,      0,      0, 0, 0);
    tbl[22] = v(0, 0, 0, 0,  0,       0,    0, 0, 0,  0,  0,      0,      0,      0,      0, 0, 0);

    // reset, then give every register a known value so config B is defined
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int k = 1; k < 32; k++) begin
      drive(0, 1, 0, rf_addr_t'(k), 0, 0, 0, 0, 0, 0);
      tick();
    end

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].we_p, tbl[i].ad, tbl[i].dd, tbl[i].ddp,
            tbl[i].sbs, tbl[i].asb, tbl[i].r0, tbl[i].r1);
      chk($sformatf("row%0d a_data0", i), ifa.data_r[0], tbl[i].a0);
      chk($sformatf("row%0d a_data1", i), ifa.data_r[1], tbl[i].a1);
      chk($sformatf("row%0d b_data0", i), ifb.data_r[0], tbl[i].b0);
      chk($sformatf("row%0d b_data1", i), ifb.data_r[1], tbl[i].b1);
      chk($sformatf("row%0d a_busy0", i), 32'(ifa.busy_r[0]), 32'(tbl[i].abz0));
      chk($sformatf("row%0d b_busy0", i), 32'(ifb.busy_r[0]), 32'(tbl[i].bbz0));
      chk($sformatf("row%0d any_busy", i), 32'(ifa.any_busy), 32'(tbl[i].any));
      tick();
    end

    for (int n = 0; n < 500; n++) begin
      logic     r, w, wp, s;
      rf_addr_t ad, as, r0, r1;
      r  = ($urandom_range(0, 39) == 0);
      w  = 1'(($urandom_range(0, 2) != 0));
      wp = 1'($urandom);
      ad = rf_addr_t'($urandom_range(0, 31));
      if (w && wp && ad == 5'd31) wp = 1'b0;
      s  = ($urandom_range(0, 2) == 0);
      as = ($urandom_range(0, 1) == 0) ? ad : rf_addr_t'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 1) == 0) ? ad : rf_addr_t'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? rf_addr_t'(ad + 1) : as;
      drive(r, w, wp, ad, $urandom, $urandom, s, as, r0, r1);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rnd%0d a_data%0d", n, p), ifa.data_r[p], m_data(ifa.addr_r[p], 1, 0));
        chk($sformatf("rnd%0d b_data%0d", n, p), ifb.data_r[p], m_data(ifa.addr_r[p], 0, 1));
        chk($sformatf("rnd%0d a_busy%0d", n, p), 32'(ifa.busy_r[p]), 32'(m_busy(ifa.addr_r[p], 1)));
        chk($sformatf("rnd%0d b_busy%0d", n, p), 32'(ifb.busy_r[p]), 32'(m_busy(ifa.addr_r[p], 0)));
      end
      begin
        bit anyp;
        anyp = 1'b0;
        for (int k = 0; k < 32; k++) anyp |= mpend[k];
        chk($sformatf("rnd%0d a_any", n), 32'(ifa.any_busy), 32'(anyp));
        chk($sformatf("rnd%0d b_any", n), 32'(ifb.any_busy), 32'(anyp));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ama_riscv_reg_file_mp.md
Name: ama_riscv_reg_file_mp

Overview:
- Parametrised successor of the core integer register file.
- Provides N asynchronous read ports and one primary write with an optional paired (rdp) write.
- Adds write-to-read bypass and a per-register pending-write scoreboard for long-latency ops (e.g. div, load miss).
- Sits in decode/ID: read data and busy flags feed operand select and hazard/stall logic; writeback drives the write port.

Parameters:
- NUM_RD_PORTS, 2, number of independent read ports (1..4).
- BYPASS, 1, when 1 a read of a register written this cycle returns the write data.
- RESET_REGS, 0, when 1 sync reset also zeroes x1..x31; when 0 contents are unaffected by reset.

Ports:
- clk  in  1  core clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- addr_r  in  NUM_RD_PORTS x rf_addr_t  read addresses.
- data_r  out  NUM_RD_PORTS x arch_width_t  read data (combinational).
- busy_r  out  NUM_RD_PORTS  pending-write flag per read port (combinational).
- we  in  1  primary write enable.
- we_p  in  1  paired write enable, qualified by we.
- addr_d  in  rf_addr_t  destination rd.
- data_d  in  arch_width_t  rd write data.
- data_dp  in  arch_width_t  rdp write data.
- sb_set  in  1  mark addr_sb pending (long-latency issue).
- addr_sb  in  rf_addr_t  scoreboard set address.
- any_busy  out  1  OR of all scoreboard bits (drain/flush status).

Behaviour:
- Reset: rst is synchronous and active-high; clk is the only clock.
  - On posedge with rst=1: all scoreboard bits cleared; if RESET_REGS=1 x1..x31 = 0; all writes and sb_set ignored that cycle.
  - Outputs after reset: busy_r=0 and any_busy=0; data_r=0 when RESET_REGS=1, otherwise reflects the retained contents.
- x0: reads return 0 and busy=0; writes and sb_set to x0 are ignored.
- Primary write: when we=1 and addr_d!=0, rf[addr_d] <= data_d at the next posedge.
- Paired write:
  - Active when we=1 and we_p=1 and get_rdp(addr_d)!=0; rf[get_rdp(addr_d)] <= data_dp.
  - we_p without we writes nothing.
  - addr_d=x31 with we_p=1 is illegal: simulation fatal assertion; RTL suppresses the rdp write and still performs the rd write.
- Scoreboard write side:
  - A qualified rd write clears sb[addr_d]; a qualified rdp write clears sb[rdp].
  - sb_set=1 sets sb[addr_sb] at the next posedge.
  - Same address set and cleared in the same cycle: set wins (new producer supersedes the returning one).
  - sb_set on an already-busy register: stays busy, no error.
- Read data, per port i, combinational:
  - addr_r[i]=0 -> data 0.
  - Else if BYPASS=1 and a qualified write targets addr_r[i] this cycle -> the matching data_d/data_dp.
  - Else rf[addr_r[i]].
  - rd has priority over rdp (they cannot collide except via the illegal x31 case).
- Read busy, per port i, combinational:
  - busy_r[i] = sb[addr_r[i]] && addr_r[i]!=0.
  - If BYPASS=1 and a qualified write targets addr_r[i] this cycle, busy_r[i]=0.
  - sb_set in the current cycle does not affect busy_r until the next cycle.
- Latency: write-to-read is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0. Scoreboard set is visible after 1 cycle.
- rst asserted mid-operation (pending long op) drops all busy bits; a later writeback to that register writes normally.

Decomposition:
- Shared package (ama_riscv_defines): rf_addr_t, arch_width_t, RF_NUM, RF_X0_ZERO, RF_X31_T6, get_rdp().
- Add to the package: MAX_RD_PORTS constant.
- Natural sub-module: ama_riscv_rf_scoreboard, holding the 32-bit busy vector with set/clear priority and any_busy, plus a busy lookup function.

Test Plan:
- Reset and x0:
  - Assert rst 1 cycle with RESET_REGS=1, read x5 -> data 0, busy 0.
  - Write x0=0xDEAD -> read x0 returns 0.
- Write/bypass:
  - we=1 addr_d=x7 data_d=0x1234 with addr_r[0]=x7 the same cycle -> data_r[0]=0x1234 (BYPASS=1).
  - With BYPASS=0 -> old value, 0x1234 on the next cycle.
- Paired write:
  - we=we_p=1 addr_d=x10 data_d=0xA data_dp=0xB -> next cycle x10=0xA, x11=0xB.
  - we_p=1 we=0 -> neither register changes.
- Scoreboard:
  - sb_set x12 -> next cycle busy_r=1 and any_busy=1.
  - Write x12=0x55 -> busy_r=0 in the write cycle (bypass), sb bit cleared after the edge, any_busy=0.
- Set/clear collision: sb_set x12 and write x12 in the same cycle -> x12 holds the new data, busy stays 1.
- Mid-op reset: sb_set x3, then rst -> busy 0; later write x3=0x9 -> reads 0x9; addr_d=x31 with we_p=1 -> assertion fires.
